// File: rtl/gpio_32_pkg.sv
// gpio_32_pkg: shared constants for the 32-pin APB GPIO bank.
//   NUM_GPIO  - number of pins (register map assumes 32)
//   DB_CNT_W  - width of the debounce threshold and per-pin counter
//   ADDR_*    - byte offsets of the eight registers
//   addr_in_range() - true when the upper address bits select the register window
package gpio_32_pkg;

  localparam int NUM_GPIO = 32;
  localparam int DB_CNT_W = 16;

  localparam logic [7:0] ADDR_GPIO_DIR     = 8'h00;
  localparam logic [7:0] ADDR_GPIO_OUT     = 8'h04;
  localparam logic [7:0] ADDR_GPIO_IN      = 8'h08;
  localparam logic [7:0] ADDR_INT_MASK     = 8'h0C;
  localparam logic [7:0] ADDR_INT_STATUS   = 8'h10;
  localparam logic [7:0] ADDR_INT_TYPE     = 8'h14;
  localparam logic [7:0] ADDR_INT_POLARITY = 8'h18;
  localparam logic [7:0] ADDR_DEBOUNCE_CFG = 8'h1C;

  // Offsets 0x00..0x1C live in the window where PADDR[7:5] is zero.
  function automatic logic addr_in_range(input logic [2:0] addr_hi);
    return (addr_hi == 3'b000);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: two-flop synchronizer plus counter-based debounce for one pin.
//   PCLK      - clock
//   PRESETn   - synchronous active-high reset
//   pin_raw   - asynchronous pad input
//   db_thresh - number of consecutive cycles a new level must persist (0 acts as 1)
//   pin_stb   - debounced level
module gpio_debounce
  import gpio_32_pkg::*;
(
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                pin_raw,
  input  logic [DB_CNT_W-1:0] db_thresh,
  output logic                pin_stb
);

  logic                meta_r;
  logic                sync_r;
  logic                stb_r;
  logic [DB_CNT_W-1:0] cnt_r;
  logic                thresh_hit_s;

  // Threshold reached; the >= compare lets a lowered threshold take effect mid-count.
  always_comb begin
    thresh_hit_s = 1'b0;
    if (db_thresh == {DB_CNT_W{1'b0}}) begin
      thresh_hit_s = 1'b1;
    end else begin
      thresh_hit_s = (cnt_r >= (db_thresh - {{(DB_CNT_W-1){1'b0}}, 1'b1}));
    end
  end

  // Synchronizer, debounce counter and stable-level register.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      stb_r  <= 1'b0;
      cnt_r  <= {DB_CNT_W{1'b0}};
    end else begin
      meta_r <= pin_raw;
      sync_r <= meta_r;
      if (sync_r == stb_r) begin
        cnt_r <= {DB_CNT_W{1'b0}};
      end else if (thresh_hit_s) begin
        stb_r <= sync_r;
        cnt_r <= {DB_CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(DB_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign pin_stb = stb_r;

endmodule

// File: rtl/gpio_32_top.sv
// gpio_32_top: 32-pin GPIO bank on an APB3 slave port.
//   PCLK, PRESETn (sync, active-high)   - clock and reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA    - APB request; PRDATA/PREADY/PSLVERR response
//   gpio_in_raw - async pad inputs, debounced per pin into the IN register
//   gpio_out    - OUT register;  gpio_oe - DIR register (1 = drive)
//   gpio_irq    - OR of masked interrupt status
module gpio_32_top
  import gpio_32_pkg::*;
(
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [7:0]          PADDR,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  input  logic [NUM_GPIO-1:0] gpio_in_raw,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                gpio_irq
);

  logic [31:0]         dir_r;
  logic [31:0]         out_r;
  logic [31:0]         mask_r;
  logic [31:0]         status_r;
  logic [31:0]         type_r;
  logic [31:0]         pol_r;
  logic [31:0]         prev_r;
  logic [DB_CNT_W-1:0] db_cfg_r;
  logic [31:0]         stb_s;
  logic [31:0]         edge_evt_s;
  logic [31:0]         level_evt_s;
  logic [31:0]         evt_s;
  logic [31:0]         clr_s;
  logic [31:0]         prdata_s;
  logic [7:0]          addr_s;
  logic                in_range_s;
  logic                wr_en_s;
  logic                unused_addr_s;

  // Byte-lane bits of the address carry no meaning.
  assign addr_s        = {PADDR[7:2], 2'b00};
  assign unused_addr_s = ^PADDR[1:0];
  assign in_range_s    = addr_in_range(PADDR[7:5]);
  assign wr_en_s       = PSEL & PENABLE & PWRITE & in_range_s;

  for (genvar g = 0; g < NUM_GPIO; g++) begin : g_db
    gpio_debounce u_db (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .pin_raw   (gpio_in_raw[g]),
      .db_thresh (db_cfg_r),
      .pin_stb   (stb_s[g])
    );
  end

  // Interrupt events per pin, selected by type (1 = edge, 0 = level).
  assign edge_evt_s  = (pol_r & stb_s & ~prev_r) | (~pol_r & ~stb_s & prev_r);
  assign level_evt_s = ~(stb_s ^ pol_r);
  assign evt_s       = (type_r & edge_evt_s) | (~type_r & level_evt_s);

  // W1C clear mask for the current cycle.
  always_comb begin
    clr_s = 32'h0000_0000;
    if (wr_en_s && (addr_s == ADDR_INT_STATUS)) begin
      clr_s = PWDATA;
    end else begin
      clr_s = 32'h0000_0000;
    end
  end

  // Read/write configuration registers; IN and STATUS are not writable here.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      dir_r    <= 32'h0000_0000;
      out_r    <= 32'h0000_0000;
      mask_r   <= 32'h0000_0000;
      type_r   <= 32'h0000_0000;
      pol_r    <= 32'h0000_0000;
      db_cfg_r <= {DB_CNT_W{1'b0}};
    end else if (wr_en_s) begin
      case (addr_s)
        ADDR_GPIO_DIR:     dir_r    <= PWDATA;
        ADDR_GPIO_OUT:     out_r    <= PWDATA;
        ADDR_INT_MASK:     mask_r   <= PWDATA;
        ADDR_INT_TYPE:     type_r   <= PWDATA;
        ADDR_INT_POLARITY: pol_r    <= PWDATA;
        ADDR_DEBOUNCE_CFG: db_cfg_r <= PWDATA[DB_CNT_W-1:0];
        default:           ;
      endcase
    end
  end

  // Interrupt status: a new event outranks a simultaneous clear.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      status_r <= 32'h0000_0000;
      prev_r   <= 32'h0000_0000;
    end else begin
      status_r <= (status_r & ~clr_s) | evt_s;
      prev_r   <= stb_s;
    end
  end

  // Combinational read mux; idle or write cycles return zero.
  always_comb begin
    prdata_s = 32'h0000_0000;
    if (PSEL && !PWRITE && in_range_s) begin
      case (addr_s)
        ADDR_GPIO_DIR:     prdata_s = dir_r;
        ADDR_GPIO_OUT:     prdata_s = out_r;
        ADDR_GPIO_IN:      prdata_s = stb_s;
        ADDR_INT_MASK:     prdata_s = mask_r;
        ADDR_INT_STATUS:   prdata_s = status_r;
        ADDR_INT_TYPE:     prdata_s = type_r;
        ADDR_INT_POLARITY: prdata_s = pol_r;
        ADDR_DEBOUNCE_CFG: prdata_s = {16'h0000, db_cfg_r};
        default:           prdata_s = 32'h0000_0000;
      endcase
    end else begin
      prdata_s = 32'h0000_0000;
    end
  end

  assign PRDATA   = prdata_s;
  assign PREADY   = 1'b1;
  assign PSLVERR  = PSEL & PENABLE & ~in_range_s;
  assign gpio_out = out_r;
  assign gpio_oe  = dir_r;
  assign gpio_irq = |(status_r & mask_r);

endmodule

// File: tb/tb_gpio_32_top.sv
module tb_gpio_32_top;

  logic        PCLK;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] gpio_in_raw;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        gpio_irq;

  gpio_32_top dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .gpio_in_raw (gpio_in_raw),
    .gpio_out    (gpio_out),
    .gpio_oe     (gpio_oe),
    .gpio_irq    (gpio_irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: register contents, 2-cycle-delayed pin view, and for each
  // pin how long the synchronized level has disagreed with the debounced one.
  logic [31:0] m_dir, m_out, m_mask, m_status, m_type, m_pol;
  logic [15:0] m_cfg;
  logic [31:0] m_s1, m_sync, m_stb, m_prev;
  int          m_run [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    if (a[7:5] != 3'b000) return 32'h0;
    case (a[4:2])
      3'd0:    return m_dir;
      3'd1:    return m_out;
      3'd2:    return m_stb;
      3'd3:    return m_mask;
      3'd4:    return m_status;
      3'd5:    return m_type;
      3'd6:    return m_pol;
      3'd7:    return {16'h0000, m_cfg};
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge: advance the model from the inputs present at the edge, then check outputs.
  task automatic tick();
    logic        rst_c, wr_c;
    logic [7:0]  a_c;
    logic [31:0] d_c, raw_c, evt, clr, nstb;
    int          thr;
    rst_c = PRESETn;
    wr_c  = PSEL & PENABLE & PWRITE;
    a_c   = PADDR;
    d_c   = PWDATA;
    raw_c = gpio_in_raw;
    @(posedge PCLK);
    if (rst_c) begin
      m_dir = 32'h0; m_out = 32'h0; m_mask = 32'h0; m_status = 32'h0;
      m_type = 32'h0; m_pol = 32'h0; m_cfg = 16'h0;
      m_s1 = 32'h0; m_sync = 32'h0; m_stb = 32'h0; m_prev = 32'h0;
      for (int i = 0; i < 32; i++) m_run[i] = 0;
    end else begin
      thr = (m_cfg == 16'h0) ? 1 : int'(m_cfg);
      nstb = m_stb;
      for (int i = 0; i < 32; i++) begin
        if (m_type[i]) evt[i] = m_pol[i] ? (m_stb[i] && !m_prev[i]) : (!m_stb[i] && m_prev[i]);
        else           evt[i] = (m_stb[i] == m_pol[i]);
        if (m_sync[i] != m_stb[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= thr) begin
            nstb[i] = m_sync[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      clr = 32'h0;
      if (wr_c && a_c[7:5] == 3'b000) begin
        case (a_c[4:2])
          3'd0:    m_dir  = d_c;
          3'd1:    m_out  = d_c;
          3'd3:    m_mask = d_c;
          3'd4:    clr    = d_c;
          3'd5:    m_type = d_c;
          3'd6:    m_pol  = d_c;
          3'd7:    m_cfg  = d_c[15:0];
          default: ;
        endcase
      end
      m_status = (m_status & ~clr) | evt;
      m_prev   = m_stb;
      m_stb    = nstb;
      m_sync   = m_s1;
      m_s1     = raw_c;
    end
    #1;
    chk("irq",    {31'h0, gpio_irq}, {31'h0, |(m_status & m_mask)});
    chk("out",    gpio_out, m_out);
    chk("oe",     gpio_oe,  m_dir);
    chk("pready", {31'h0, PREADY}, 32'h1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    tick();
    PENABLE = 1'b1;
    #1;
    chk("wr_pslverr", {31'h0, PSLVERR}, {31'h0, (a[7:5] != 3'b000)});
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    tick();
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    chk("rd_data",    PRDATA, m_read(a));
    chk("rd_pslverr", {31'h0, PSLVERR}, {31'h0, (a[7:5] != 3'b000)});
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, v;
    logic [7:0]  ra;
    logic [31:0] rdat;
    PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h00; PWDATA = 32'h0; gpio_in_raw = 32'h0;
    m_dir = 32'h0; m_out = 32'h0; m_mask = 32'h0; m_status = 32'h0;
    m_type = 32'h0; m_pol = 32'h0; m_cfg = 16'h0;
    m_s1 = 32'h0; m_sync = 32'h0; m_stb = 32'h0; m_prev = 32'h0;
    for (int i = 0; i < 32; i++) m_run[i] = 0;

    // Reset, then all-ones status one cycle later with irq held low by mask=0.
    ticks(3);
    chk("rst_oe",  gpio_oe,  32'h0);
    chk("rst_out", gpio_out, 32'h0);
    PRESETn = 1'b0;
    tick();
    apb_read(8'h10, rd);
    chk("rst_status", rd, 32'hFFFF_FFFF);
    chk("rst_irq", {31'h0, gpio_irq}, 32'h0);

    // DIR / OUT
    apb_write(8'h00, 32'h0000_00FF);
    apb_write(8'h04, 32'hA5A5_00FF);
    chk("oe_val",  gpio_oe,  32'h0000_00FF);
    chk("out_val", gpio_out, 32'hA5A5_00FF);
    apb_read(8'h00, rd); chk("dir_rb", rd, 32'h0000_00FF);
    apb_read(8'h04, rd); chk("out_rb", rd, 32'hA5A5_00FF);

    // Debounce N=4: short glitches rejected, 6-cycle hold accepted
    apb_write(8'h1C, 32'h0000_0004);
    gpio_in_raw[0] = 1'b1; tick();
    gpio_in_raw[0] = 1'b0; tick();
    gpio_in_raw[0] = 1'b1; tick();
    gpio_in_raw[0] = 1'b0; tick();
    ticks(5);
    apb_read(8'h08, rd); chk("db_glitch", {31'h0, rd[0]}, 32'h0);
    gpio_in_raw[0] = 1'b1;
    ticks(6);
    apb_read(8'h08, rd); chk("db_hold", {31'h0, rd[0]}, 32'h1);

    // Rising-edge interrupt on pin0
    gpio_in_raw[0] = 1'b0;
    ticks(8);
    apb_write(8'h1C, 32'h0000_0003);
    apb_write(8'h14, 32'h0000_0001);
    apb_write(8'h18, 32'h0000_0001);
    apb_write(8'h0C, 32'h0000_0001);
    apb_write(8'h10, 32'hFFFF_FFFF);
    gpio_in_raw[0] = 1'b1;
    ticks(8);
    apb_read(8'h10, rd);
    chk("edge_set", {31'h0, rd[0]}, 32'h1);
    chk("edge_irq", {31'h0, gpio_irq}, 32'h1);
    apb_write(8'h10, 32'h0000_0001);
    ticks(3);
    apb_read(8'h10, rd);
    chk("edge_clr", {31'h0, rd[0]}, 32'h0);
    chk("edge_irq_clr", {31'h0, gpio_irq}, 32'h0);

    // Level-high interrupt on pin0: clear fails while high, succeeds after
    apb_write(8'h1C, 32'hFFFF_0002);
    apb_read(8'h1C, rd); chk("cfg_rb", rd, 32'h0000_0002);
    apb_write(8'h14, 32'h0000_0000);
    apb_read(8'h10, rd);
    chk("lvl_set", {31'h0, rd[0]}, 32'h1);
    chk("lvl_irq", {31'h0, gpio_irq}, 32'h1);
    apb_write(8'h10, 32'h0000_0001);
    apb_read(8'h10, rd);
    chk("lvl_hold", {31'h0, rd[0]}, 32'h1);
    gpio_in_raw[0] = 1'b0;
    ticks(6);
    apb_write(8'h10, 32'h0000_0001);
    apb_read(8'h10, rd);
    chk("lvl_clr", {31'h0, rd[0]}, 32'h0);
    chk("lvl_irq_clr", {31'h0, gpio_irq}, 32'h0);

    // Out-of-range read, write to IN ignored
    apb_read(8'h20, rd);
    chk("bad_rd", rd, 32'h0);
    apb_read(8'h08, v);
    apb_write(8'h08, ~v);
    apb_read(8'h08, rd);
    chk("in_ro", rd, v);

    // Same-cycle W1C and rising-edge event: set wins
    apb_write(8'h1C, 32'h0000_0000);
    apb_write(8'h14, 32'h0000_0001);
    apb_write(8'h10, 32'h0000_0001);
    apb_read(8'h10, rd);
    chk("race_pre", {31'h0, rd[0]}, 32'h0);
    gpio_in_raw[0] = 1'b1;
    tick();
    tick();
    apb_write(8'h10, 32'h0000_0001);
    apb_read(8'h10, rd);
    chk("race_setwins", {31'h0, rd[0]}, 32'h1);

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      gpio_in_raw = gpio_in_raw ^ ($urandom & $urandom & $urandom & $urandom);
      case ($urandom_range(0, 3))
        0: tick();
        1: begin
          ra = 8'($urandom_range(0, 63));
          apb_read(ra, rdat);
        end
        2: begin
          ra = 8'($urandom_range(0, 63)) & 8'hFC;
          rdat = $urandom;
          if (ra[4:2] == 3'd7) rdat[15:0] = 16'($urandom_range(0, 4));
          apb_write(ra, rdat);
        end
        default: apb_write(8'h10, $urandom);
      endcase
    end

    // Reset in the middle of a debounce
    apb_write(8'h1C, 32'h0000_000A);
    gpio_in_raw = 32'hFFFF_FFFF;
    ticks(5);
    PRESETn = 1'b1;
    tick();
    PRESETn = 1'b0;
    apb_read(8'h08, rd); chk("mid_rst_in", rd, 32'h0);
    apb_read(8'h00, rd); chk("mid_rst_dir", rd, 32'h0);
    apb_read(8'h04, rd); chk("mid_rst_out", rd, 32'h0);
    apb_read(8'h0C, rd); chk("mid_rst_mask", rd, 32'h0);
    apb_read(8'h14, rd); chk("mid_rst_type", rd, 32'h0);
    apb_read(8'h18, rd); chk("mid_rst_pol", rd, 32'h0);
    apb_read(8'h1C, rd); chk("mid_rst_cfg", rd, 32'h0);
    apb_read(8'h10, rd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
